// File: rtl/shiftreg_debounce.sv
// Debounces the parallel frame from the shiftreg chain. A value must differ from the
// published state for FILTER consecutive frames before it is accepted.
// The optional stale watchdog is enabled by defining SHIFTREG_DEBOUNCE_STALE_EN.
module shiftreg_debounce #(
  parameter int WIDTH   = 8,
  parameter int FILTER  = 3,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             frame,
  output logic             stale
);

  localparam logic [31:0] FILTER_EFF = (FILTER < 1) ? 32'd1 : 32'(FILTER);
  localparam int          CW         = ($clog2(FILTER + 1) < 1) ? 1 : $clog2(FILTER + 1);

  logic             load_q;
  logic             tick;
  logic             primed;
  logic [WIDTH-1:0] snap;
  logic [CW-1:0]    cnt   [WIDTH];
  logic [CW-1:0]    cnt_n [WIDTH];
  logic [WIDTH-1:0] state_n;
  logic [WIDTH-1:0] rise_n;
  logic [WIDTH-1:0] fall_n;

  // Per-bit filter decision for the snapshotted frame.
  always_comb begin
    state_n = state;
    rise_n  = '0;
    fall_n  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_n[i] = cnt[i];
      if (snap[i] == state[i]) begin
        cnt_n[i] = '0;
      end else if (32'(cnt[i]) + 32'd1 >= FILTER_EFF) begin
        state_n[i] = snap[i];
        cnt_n[i]   = '0;
        rise_n[i]  = snap[i];
        fall_n[i]  = ~snap[i];
      end else begin
        cnt_n[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_q <= 1'b1;
      tick   <= 1'b0;
      primed <= 1'b0;
      snap   <= '0;
      state  <= '0;
      rise   <= '0;
      fall   <= '0;
      frame  <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      load_q <= load;
      tick   <= load_q & ~load;
      if (load_q && !load) snap <= data_in;
      frame  <= tick;
      rise   <= '0;
      fall   <= '0;
      if (tick) begin
        // The first frame after reset is taken as-is so the state starts out valid.
        if (!primed) begin
          state  <= snap;
          primed <= 1'b1;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          state <= state_n;
          rise  <= rise_n;
          fall  <= fall_n;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_n[i];
        end
      end
    end
  end

`ifdef SHIFTREG_DEBOUNCE_STALE_EN
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  logic [31:0] idle_cnt;
  logic        stale_q;

  // Watchdog: saturating idle counter, cleared whenever a frame is evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
      stale_q  <= 1'b1;
    end else begin
      if (tick)                      idle_cnt <= '0;
      else if (idle_cnt < TIMEOUT_W) idle_cnt <= idle_cnt + 32'd1;
      if (tick)                               stale_q <= 1'b0;
      else if (idle_cnt == TIMEOUT_W - 32'd1) stale_q <= 1'b1;
    end
  end

  assign stale = stale_q;
`else
  assign stale = 1'b0;
`endif

endmodule

// File: doc/shiftreg_debounce.md
Name: shiftreg_debounce

Overview:
- Downstream consumer of the shift-register input chain.
- Takes the raw parallel input vector and its load strobe from the shiftreg block.
- Detects each completed frame and debounces every bit over FILTER consecutive frames.
- Publishes a stable input state with one-cycle rise/fall event pulses per bit for the HAL-facing interface.

Parameters:
WIDTH, 8, number of input bits; must match the upstream shiftreg WIDTH
FILTER, 3, consecutive frames a differing value must persist before acceptance; 0 is treated as 1; maximum 255
TIMEOUT, 1000000, clk cycles without a frame before stale asserts; used only with the optional feature

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load  in  1  load strobe from shiftreg; the 1->0 transition marks a completed frame
data_in  in  WIDTH  raw input bits from shiftreg; valid while load is low after the falling edge
state  out  WIDTH  debounced input state
rise  out  WIDTH  one-cycle pulse per bit on an accepted 0->1 change
fall  out  WIDTH  one-cycle pulse per bit on an accepted 1->0 change
frame  out  1  one-cycle pulse per processed frame
stale  out  1  no frame within TIMEOUT cycles; constant 0 when the feature is absent

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high. load is in the clk domain, so no synchroniser is used.
- Reset values:
  - state = 0, rise = 0, fall = 0, frame = 0.
  - All per-bit counters = 0, load_q = 1, primed = 0.
  - stale = 1 with the feature, 0 without.
- Frame detect (edge E, where load_q == 1 and load == 0):
  - snap <= data_in; tick <= 1; load_q tracks load every cycle.
- Evaluation (edge E+1, when tick == 1):
  - frame pulses high for exactly the cycle after E+1.
  - rise/fall are valid in that same cycle and are 0 in every other cycle.
  - Latency from sampled load fall to visible state/events: 2 clk edges.
- First frame after reset (primed == 0):
  - state <= snap; counters cleared; primed <= 1.
  - No rise/fall pulses for this frame.
- Per bit i on subsequent frames:
  - snap[i] == state[i]: cnt[i] <= 0.
  - Otherwise, if cnt[i] + 1 >= FILTER: state[i] <= snap[i], cnt[i] <= 0, and rise[i] or fall[i] pulses according to direction.
  - Otherwise: cnt[i] <= cnt[i] + 1.
- Counter width is clog2(FILTER + 1), minimum 1. Counters never exceed FILTER - 1, so there is no wrap.
- A bounce (value returns before FILTER frames) clears the counter; no event is produced.
- Independent bits changing on the same frame produce pulses in the same cycle.
- load held high or held low generates no ticks; data_in changes outside a tick are ignored.
- A new tick can never overlap evaluation, since upstream frames are at least DIVIDER cycles apart. If back-to-back falls did occur, each is processed in order, one per cycle.
- rst mid-frame or mid-filter: everything returns to reset values on the next edge; the next frame re-primes.

Optional Feature:
- Macro: SHIFTREG_DEBOUNCE_STALE_EN.
- With the macro defined:
  - An idle counter of 32 bits saturates at TIMEOUT.
  - The counter clears to 0 on every tick; otherwise it increments each cycle.
  - stale <= 1 when the counter reaches TIMEOUT - 1 and stays set; stale <= 0 on the evaluation edge of the next frame.
  - While stale, state is held and no events are generated. Counters are preserved.
  - Reset value of stale is 1, cleared by the first frame.
- Without the macro: no idle counter; stale is tied to 0.

Test Plan:
1. rst, then one frame with data_in=0xA5 -> state=0xA5 two edges after load fall; rise=fall=0; frame high for one cycle.
2. FILTER=3, state=0xA5, three frames with data_in=0xA4 -> state unchanged after frames 1 and 2; after frame 3 state=0xA4, fall=0x01 for one cycle.
3. FILTER=3, state=0xA5, frames 0xA7, 0xA7, 0xA5, 0xA7 -> no event at any point; bit1 counter is back to 1 after the last frame.
4. FILTER=3, state=0xA5, three frames of 0x5A -> state=0x5A, rise=0x5A and fall=0xA5 in the same cycle.
5. load held high 50 cycles while data_in toggles randomly, then rst asserted mid-filter -> no frame/event; after rst, state=0 and the next frame loads directly with no events.
6. SHIFTREG_DEBOUNCE_STALE_EN, TIMEOUT=100, after rst no frames -> stale stays 1. One frame -> stale=0; 100 idle cycles -> stale=1; next frame -> stale=0 and state updates normally.
